// File: rtl/pipe_stage_elastic.sv
// Two-entry elastic pipeline stage (main + skid register) with flush, occupancy
// reporting and a saturating counter of cycles where the output presents nothing.
module pipe_stage_elastic #(
    parameter int DATA_W     = 32,
    parameter int CTRL_W     = 16,
    parameter int FLUSH_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic [CTRL_W-1:0] in_ctrl,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [1:0]        occupancy,
    input  logic              cnt_clr,
    output logic [CNT_W-1:0]  bubble_cnt
);

    logic              r_m_valid;
    logic [DATA_W-1:0] r_m_data;
    logic [CTRL_W-1:0] r_m_ctrl;
    logic              r_s_valid;
    logic [DATA_W-1:0] r_s_data;
    logic [CTRL_W-1:0] r_s_ctrl;
    logic [CNT_W-1:0]  r_bubble_cnt;

    logic              w_in_fire;
    logic              w_out_fire;
    logic              w_m_valid_nxt;
    logic [DATA_W-1:0] w_m_data_nxt;
    logic [CTRL_W-1:0] w_m_ctrl_nxt;
    logic              w_s_valid_nxt;
    logic [DATA_W-1:0] w_s_data_nxt;
    logic [CTRL_W-1:0] w_s_ctrl_nxt;
    logic [CNT_W-1:0]  w_bubble_nxt;

    // Next-state for M and S; S only fills while M is stalled, so M-before-S order holds.
    always_comb begin
        w_in_fire     = in_valid & ~r_s_valid;
        w_out_fire    = r_m_valid & out_ready;
        w_m_valid_nxt = r_m_valid;
        w_m_data_nxt  = r_m_data;
        w_m_ctrl_nxt  = r_m_ctrl;
        w_s_valid_nxt = r_s_valid;
        w_s_data_nxt  = r_s_data;
        w_s_ctrl_nxt  = r_s_ctrl;
        if (flush) begin
            w_m_valid_nxt = 1'b0;
            w_s_valid_nxt = 1'b0;
            w_m_ctrl_nxt  = {CTRL_W{1'b0}};
            w_s_ctrl_nxt  = {CTRL_W{1'b0}};
            if (FLUSH_DATA != 0) begin
                w_m_data_nxt = {DATA_W{1'b0}};
                w_s_data_nxt = {DATA_W{1'b0}};
            end else begin
                w_m_data_nxt = r_m_data;
                w_s_data_nxt = r_s_data;
            end
        end else if (w_out_fire | ~r_m_valid) begin
            if (r_s_valid) begin
                w_m_valid_nxt = 1'b1;
                w_m_data_nxt  = r_s_data;
                w_m_ctrl_nxt  = r_s_ctrl;
                w_s_valid_nxt = 1'b0;
            end else if (w_in_fire) begin
                w_m_valid_nxt = 1'b1;
                w_m_data_nxt  = in_data;
                w_m_ctrl_nxt  = in_ctrl;
            end else begin
                w_m_valid_nxt = 1'b0;
            end
        end else if (w_in_fire) begin
            w_s_valid_nxt = 1'b1;
            w_s_data_nxt  = in_data;
            w_s_ctrl_nxt  = in_ctrl;
        end else begin
            w_s_valid_nxt = r_s_valid;
        end
    end

    // Bubble counter next value: clear wins, otherwise saturating increment on empty output.
    always_comb begin
        w_bubble_nxt = r_bubble_cnt;
        if (cnt_clr) begin
            w_bubble_nxt = {CNT_W{1'b0}};
        end else if (~r_m_valid & ~flush & ~(&r_bubble_cnt)) begin
            w_bubble_nxt = r_bubble_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            w_bubble_nxt = r_bubble_cnt;
        end
    end

    // State registers, updated on the falling clock edge.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_m_valid    <= 1'b0;
            r_m_data     <= {DATA_W{1'b0}};
            r_m_ctrl     <= {CTRL_W{1'b0}};
            r_s_valid    <= 1'b0;
            r_s_data     <= {DATA_W{1'b0}};
            r_s_ctrl     <= {CTRL_W{1'b0}};
            r_bubble_cnt <= {CNT_W{1'b0}};
        end else begin
            r_m_valid    <= w_m_valid_nxt;
            r_m_data     <= w_m_data_nxt;
            r_m_ctrl     <= w_m_ctrl_nxt;
            r_s_valid    <= w_s_valid_nxt;
            r_s_data     <= w_s_data_nxt;
            r_s_ctrl     <= w_s_ctrl_nxt;
            r_bubble_cnt <= w_bubble_nxt;
        end
    end

    assign out_valid  = r_m_valid;
    assign out_data   = r_m_data;
    assign out_ctrl   = r_m_ctrl;
    assign in_ready   = ~r_s_valid;
    assign occupancy  = {1'b0, r_m_valid} + {1'b0, r_s_valid};
    assign bubble_cnt = r_bubble_cnt;

endmodule

// File: doc/pipe_stage_elastic.md
PIPE_STAGE_ELASTIC -- requirements
Module: pipe_stage_elastic

Interface
REQ-001 SHALL have parameter DATA_W, default 32: width of the datapath payload (operands, PC, immediate).
REQ-002 SHALL have parameter CTRL_W, default 16: width of the control payload (RegWrite, ResultSrc, MemWrite, Jump, Branch, ALU control).
REQ-003 SHALL have parameter FLUSH_DATA, default 1: 1 = flush zeroes the data payload; 0 = flush leaves the data payload unchanged.
REQ-004 SHALL have parameter CNT_W, default 16: width of the bubble counter.
REQ-005 clk  input  1  clock; all registers update on its falling edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 flush  input  1  synchronous kill of every held entry.
REQ-008 in_valid  input  1  upstream presents an entry.
REQ-009 in_ready  output  1  stage can accept an entry.
REQ-010 in_data  input  DATA_W  upstream data payload.
REQ-011 in_ctrl  input  CTRL_W  upstream control payload.
REQ-012 out_valid  output  1  stage presents an entry.
REQ-013 out_ready  input  1  downstream accepts the entry (0 = downstream stall).
REQ-014 out_data  output  DATA_W  data payload of the presented entry.
REQ-015 out_ctrl  output  CTRL_W  control payload of the presented entry.
REQ-016 occupancy  output  2  number of entries held (0..2).
REQ-017 cnt_clr  input  1  synchronous clear of bubble_cnt.
REQ-018 bubble_cnt  output  CNT_W  saturating count of empty-output cycles.

Function
REQ-019 The stage SHALL hold two entries: main register M, which drives the outputs, and skid register S; each SHALL carry a valid bit.
REQ-020 out_valid SHALL equal M.valid, and out_data/out_ctrl SHALL equal M's payload; no combinational path SHALL exist from in_* to out_*.
REQ-021 in_ready SHALL equal ~S.valid and SHALL depend only on state, with no combinational path from out_ready.
REQ-022 Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-023 Without flush, if out_fire or ~M.valid: M SHALL load S when S.valid (S then cleared); else M SHALL load in_* when in_fire; else M.valid SHALL become 0.
REQ-024 In the REQ-023 case with S.valid and in_fire together, the input SHALL go to S, preserving order.
REQ-025 Without flush, if M.valid & ~out_ready and in_fire: S SHALL load in_*.
REQ-026 Entries SHALL leave in arrival order; no entry SHALL be duplicated or lost except by flush.
REQ-027 Minimum latency SHALL be 1 edge: an entry accepted at edge n SHALL appear on out_* after edge n when the stage was empty.
REQ-028 Flush SHALL clear M.valid and S.valid, zero M/S control payloads and, when FLUSH_DATA=1, zero data payloads.
REQ-029 flush SHALL take priority over all transfers: an input accepted in the flush cycle SHALL be discarded, and an out_fire in that cycle SHALL still count as delivered.
REQ-030 After a flush, in_ready SHALL be 1 and out_valid SHALL be 0 on the next cycle.
REQ-031 occupancy SHALL equal M.valid + S.valid.
REQ-032 bubble_cnt SHALL increment on each edge where out_valid=0 and flush=0, and SHALL saturate at 2^CNT_W-1.
REQ-033 cnt_clr SHALL zero bubble_cnt and SHALL take priority over increment.
REQ-034 M.valid=0 SHALL always coincide with S.valid=0; the state S-valid-without-M-valid SHALL be unreachable.

Reset
REQ-035 While reset=0, M and S SHALL be cleared: valid 0, data 0, control 0.
REQ-036 While reset=0, outputs SHALL be: out_valid=0, out_data=0, out_ctrl=0, in_ready=1, occupancy=0, bubble_cnt=0.
REQ-037 Reset assertion SHALL take effect immediately without a clock edge and SHALL override flush and any transfer in progress.
REQ-038 After reset deassertion, the first falling edge SHALL be able to accept an entry.

Verification
REQ-039 Stream: in_data=1..8 back-to-back, out_ready=1 -> out_data=1..8 on consecutive cycles, each one edge late; occupancy stays 1; in_ready stays 1.
REQ-040 Stall: fill with A=0x11, B=0x22 while out_ready=0 -> occupancy=2, in_ready=0, C held upstream; then out_ready=1 -> outputs A, B, C in order with no loss.
REQ-041 Flush with occupancy=2 and in_valid=1 -> next cycle out_valid=0, out_ctrl=0, out_data=0 (FLUSH_DATA=1) or unchanged (FLUSH_DATA=0), in_ready=1; the flushed input never appears.
REQ-042 Counter: CNT_W=4, idle 20 edges -> bubble_cnt=15 held; cnt_clr together with an idle edge -> 0.
REQ-043 Async reset mid-stream with occupancy=2 -> outputs reach REQ-036 values before the next edge; the stream restarts cleanly afterwards.
REQ-044 Random in_valid/out_ready/flush for 10k cycles against a queue scoreboard -> order preserved, no duplicates, occupancy never exceeds 2.
